fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 10'd0: fetch address loaded on reset.
REQ-002 The block SHALL have parameter INSTR_W, default 16: instruction width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 8: maximum cycles oMemReq may wait for iMemAck.
REQ-004 The block SHALL have port Clock, input, 1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port iStall, input, 1: decode cannot accept the issued instruction.
REQ-007 The block SHALL have port iBranchTaken, input, 1: one-cycle redirect request.
REQ-008 The block SHALL have port iBranchTarget, input, 10: redirect address.
REQ-009 The block SHALL have port iMemAck, input, 1: instruction memory returns data this cycle.
REQ-010 The block SHALL have port iMemData, input, INSTR_W: instruction word, valid when iMemAck=1.
REQ-011 The block SHALL have port oMemReq, output, 1: instruction memory read request.
REQ-012 The block SHALL have port oMemAddr, output, 10: read address.
REQ-013 The block SHALL have port oInstr, output, INSTR_W: issued instruction.
REQ-014 The block SHALL have port oInstrValid, output, 1: oInstr/oPC valid.
REQ-015 The block SHALL have port oPC, output, 10: address of oInstr.
REQ-016 The block SHALL have port wPC_salida, output, 10: current fetch PC register.
REQ-017 The block SHALL have port oError, output, 1: sticky memory-timeout flag.

Function
REQ-018 The block SHALL implement states FETCH, ISSUE, FLUSH and HALT.
REQ-019 In FETCH, oMemReq SHALL be 1 and oMemAddr SHALL equal the PC; both SHALL hold until iMemAck is sampled 1; an ack in the same cycle as the request is legal.
REQ-020 iMemAck SHALL be ignored while oMemReq=0.
REQ-021 From FETCH on iMemAck without branch: capture iMemData into oInstr and PC into oPC, PC<=PC+1 (10-bit wrap, 1023+1=0), and move to ISSUE.
REQ-022 In ISSUE, oInstrValid SHALL be 1 and oMemReq SHALL be 0.
REQ-023 From ISSUE with iStall=1: stay in ISSUE, with oInstr and oPC held.
REQ-024 From ISSUE with iStall=0: move to FETCH; steady-state throughput is one instruction per 2 cycles with zero-wait memory.
REQ-025 On iBranchTaken in ISSUE: PC<=iBranchTarget, the held instruction is dropped (oInstrValid=0 next cycle), and the state moves to FETCH; branch has priority over iStall.
REQ-026 On iBranchTaken in FETCH with iMemAck=1 in the same cycle: the returned data is discarded, PC<=iBranchTarget, and the state stays in FETCH.
REQ-027 On iBranchTaken in FETCH with iMemAck=0: PC<=iBranchTarget and the state moves to FLUSH.
REQ-028 In FLUSH, oMemReq SHALL stay 1 with the old address until ack; the data is discarded; the state then moves to FETCH at the new PC.
REQ-029 A further branch in FLUSH SHALL overwrite PC with the newest target.
REQ-030 A wait counter SHALL count consecutive cycles with oMemReq=1 and iMemAck=0, and clear on ack.
REQ-031 When the wait counter reaches TIMEOUT, the state SHALL move to HALT and oError<=1.
REQ-032 In HALT, oMemReq=0 and oInstrValid=0; HALT is left only by Reset.

Reset
REQ-033 While Reset=1, asynchronously: state=FETCH, PC=RESET_PC, oInstr=0, oPC=0, oInstrValid=0, oError=0, wait counter=0.
REQ-034 Following the REQ-033 reset values, outputs SHALL be: oMemReq=1 and oMemAddr=RESET_PC, both while Reset is still asserted.
REQ-035 Reset asserted mid-transaction SHALL abandon any outstanding request; a late ack after reset SHALL be treated as the ack for RESET_PC.

Verification
REQ-036 Reset, then iMemAck tied 1, iStall=0 -> oPC sequence 0,1,2,3 with oInstrValid toggling 0,1,0,1 and wPC_salida incrementing every 2 cycles.
REQ-037 PC=1023 fetched -> oPC=1023 issued and wPC_salida wraps to 0.
REQ-038 ISSUE with iStall=1 for 3 cycles -> oInstrValid=1 and oInstr/oPC stable for 4 cycles, and no memory request.
REQ-039 Branch to 10'd200 in ISSUE with iStall=1 -> next cycle oInstrValid=0 and oMemAddr=200; the next issued oPC=200.
REQ-040 Branch to 10'd50 while a request to 5 is pending (ack 2 cycles later) -> oMemAddr holds 5 until ack, data is not issued, then oMemAddr=50.
REQ-041 iMemAck held 0 -> after TIMEOUT=8 cycles oError=1, oMemReq=0, and the block stays halted until Reset.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch controller bus: decode handshake, branch redirect,
// instruction memory request/response and status.
interface fetch_if #(
    parameter int INSTR_W = 16
);
    logic               iStall;
    logic               iBranchTaken;
    logic [9:0]         iBranchTarget;
    logic               iMemAck;
    logic [INSTR_W-1:0] iMemData;
    logic               oMemReq;
    logic [9:0]         oMemAddr;
    logic [INSTR_W-1:0] oInstr;
    logic               oInstrValid;
    logic [9:0]         oPC;
    logic [9:0]         wPC_salida;
    logic               oError;

    modport master (
        input  iStall, iBranchTaken, iBranchTarget,
        input  iMemAck, iMemData,
        output oMemReq, oMemAddr, oInstr, oInstrValid,
        output oPC, wPC_salida, oError
    );

    modport slave (
        output iStall, iBranchTaken, iBranchTarget,
        output iMemAck, iMemData,
        input  oMemReq, oMemAddr, oInstr, oInstrValid,
        input  oPC, wPC_salida, oError
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: request/issue loop with branch
// redirect, in-flight flush and memory timeout halt.
module fetch_controller #(
    parameter logic [9:0] RESET_PC = 10'd0,
    parameter int         INSTR_W  = 16,
    parameter int         TIMEOUT  = 8
) (
    input  logic     Clock,
    input  logic     Reset,
    fetch_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]         state;
    logic [9:0]         pc;
    logic [9:0]         flush_addr;
    logic [9:0]         opc;
    logic [INSTR_W-1:0] instr;
    logic               err;
    logic [CW-1:0]      wait_cnt;

    logic req;
    logic ack;
    logic timeout_hit;

    // A request is outstanding in FETCH and FLUSH; acks elsewhere are ignored.
    assign req         = (state == FETCH) || (state == FLUSH);
    assign ack         = req && bus.iMemAck;
    assign timeout_hit = req && !bus.iMemAck &&
                         (wait_cnt == CW'(TIMEOUT - 1));

    // State, PC and issued-instruction registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            flush_addr <= RESET_PC;
            opc        <= '0;
            instr      <= '0;
            err        <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (req) begin
                wait_cnt <= ack ? '0 : wait_cnt + CW'(1);
            end
            case (state)
                FETCH: begin
                    if (timeout_hit) begin
                        state <= HALT;
                        err   <= 1'b1;
                    end else if (ack) begin
                        if (bus.iBranchTaken) begin
                            pc <= bus.iBranchTarget;
                        end else begin
                            instr <= bus.iMemData;
                            opc   <= pc;
                            pc    <= pc + 10'd1;
                            state <= ISSUE;
                        end
                    end else if (bus.iBranchTaken) begin
                        flush_addr <= pc;
                        pc         <= bus.iBranchTarget;
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (timeout_hit) begin
                        state <= HALT;
                        err   <= 1'b1;
                    end else begin
                        if (bus.iBranchTaken) begin
                            pc <= bus.iBranchTarget;
                        end
                        if (ack) begin
                            state <= FETCH;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.iBranchTaken) begin
                        pc    <= bus.iBranchTarget;
                        state <= FETCH;
                    end else if (!bus.iStall) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Outputs: the flush keeps presenting the abandoned address.
    always_comb begin
        bus.oMemReq     = req;
        bus.oMemAddr    = (state == FLUSH) ? flush_addr : pc;
        bus.oInstr      = instr;
        bus.oInstrValid = (state == ISSUE);
        bus.oPC         = opc;
        bus.wPC_salida  = pc;
        bus.oError      = err;
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_fetch_controller;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_if #(.INSTR_W(16)) bus ();

    fetch_controller #(
        .RESET_PC (10'd0),
        .INSTR_W  (16),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: what the fetch unit is doing, not how.
    logic [9:0]  m_pc;
    logic [9:0]  m_req_addr;
    logic        m_have;
    logic        m_discard;
    logic        m_halt;
    int          m_wait;
    logic [15:0] m_instr;
    logic [9:0]  m_opc;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 10'd0; m_req_addr = 10'd0;
        m_have = 1'b0; m_discard = 1'b0; m_halt = 1'b0;
        m_wait = 0; m_instr = '0; m_opc = '0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic br,
                              input logic [9:0] tg, input logic ak,
                              input logic [15:0] d);
        if (m_halt) return;
        if (m_have) begin
            if (br) begin
                m_pc = tg; m_have = 1'b0;
            end else if (!st) begin
                m_have = 1'b0;
            end
        end else if (ak) begin
            m_wait = 0;
            if (m_discard) begin
                m_discard = 1'b0;
                if (br) m_pc = tg;
            end else if (br) begin
                m_pc = tg;
            end else begin
                m_instr = d; m_opc = m_pc;
                m_pc = m_pc + 10'd1; m_have = 1'b1;
            end
        end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin
                m_halt = 1'b1; m_err = 1'b1;
            end else if (br) begin
                if (!m_discard) begin
                    m_req_addr = m_pc; m_discard = 1'b1;
                end
                m_pc = tg;
            end
        end
    endtask

    task automatic compare_model();
        logic exp_req;
        exp_req = !m_halt && !m_have;
        chk("oMemReq", 32'(bus.oMemReq), 32'(exp_req));
        if (exp_req)
            chk("oMemAddr", 32'(bus.oMemAddr),
                32'(m_discard ? m_req_addr : m_pc));
        chk("oInstrValid", 32'(bus.oInstrValid),
            32'(m_have && !m_halt));
        chk("oInstr", 32'(bus.oInstr), 32'(m_instr));
        chk("oPC", 32'(bus.oPC), 32'(m_opc));
        chk("wPC_salida", 32'(bus.wPC_salida), 32'(m_pc));
        chk("oError", 32'(bus.oError), 32'(m_err));
    endtask

    task automatic drive(input logic st, input logic br,
                         input logic [9:0] tg, input logic ak,
                         input logic [15:0] d);
        bus.iStall = st; bus.iBranchTaken = br;
        bus.iBranchTarget = tg; bus.iMemAck = ak; bus.iMemData = d;
    endtask

    // One clock: apply inputs at negedge, compare at the next negedge.
    task automatic cycle(input logic st, input logic br,
                         input logic [9:0] tg, input logic ak,
                         input logic [15:0] d);
        drive(st, br, tg, ak, d);
        model_step(st, br, tg, ak, d);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
        #1;
        model_reset();
        compare_model();
        chk("rst_req", 32'(bus.oMemReq), 32'd1);
        chk("rst_addr", 32'(bus.oMemAddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        compare_model();
    endtask

    initial begin
        drive(1'b0, 1'b0, 10'd0, 1'b0, 16'h0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Zero-wait streaming: one issue every two cycles.
        cycle(0, 0, 0, 1, 16'h1000);
        chk("s_v1", 32'(bus.oInstrValid), 32'd1);
        chk("s_pc0", 32'(bus.oPC), 32'd0);
        chk("s_w1", 32'(bus.wPC_salida), 32'd1);
        cycle(0, 0, 0, 1, 16'h1001);
        chk("s_v0", 32'(bus.oInstrValid), 32'd0);
        cycle(0, 0, 0, 1, 16'h1002);
        chk("s_pc1", 32'(bus.oPC), 32'd1);
        chk("s_w2", 32'(bus.wPC_salida), 32'd2);
        cycle(0, 0, 0, 1, 16'h1003);
        cycle(0, 0, 0, 1, 16'h1004);
        chk("s_pc2", 32'(bus.oPC), 32'd2);
        cycle(0, 0, 0, 1, 16'h1005);
        cycle(0, 0, 0, 1, 16'h1006);
        chk("s_pc3", 32'(bus.oPC), 32'd3);
        cycle(0, 0, 0, 1, 16'h1007);

        // Branch with same-cycle ack to 1023, then wrap.
        cycle(0, 1, 10'd1023, 1, 16'hDEAD);
        chk("b_v0", 32'(bus.oInstrValid), 32'd0);
        chk("b_w", 32'(bus.wPC_salida), 32'd1023);
        cycle(0, 0, 0, 1, 16'hA5A5);
        chk("w_pc", 32'(bus.oPC), 32'd1023);
        chk("w_wrap", 32'(bus.wPC_salida), 32'd0);

        // Stall holds the issued instruction with no request.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 16'h5555);
            chk("st_v", 32'(bus.oInstrValid), 32'd1);
            chk("st_i", 32'(bus.oInstr), 32'hA5A5);
            chk("st_req", 32'(bus.oMemReq), 32'd0);
        end
        cycle(1, 1, 10'd200, 1, 16'h5555);
        chk("br_v0", 32'(bus.oInstrValid), 32'd0);
        chk("br_addr", 32'(bus.oMemAddr), 32'd200);
        cycle(0, 0, 0, 1, 16'h0200);
        chk("br_pc", 32'(bus.oPC), 32'd200);

        // Branch while a request to 5 is waiting.
        cycle(0, 1, 10'd5, 0, 16'h0);
        chk("f_a5", 32'(bus.oMemAddr), 32'd5);
        cycle(0, 1, 10'd50, 0, 16'h0);
        chk("f_hold", 32'(bus.oMemAddr), 32'd5);
        cycle(0, 0, 0, 0, 16'h0);
        chk("f_hold2", 32'(bus.oMemAddr), 32'd5);
        cycle(0, 0, 0, 1, 16'hBEEF);
        chk("f_v0", 32'(bus.oInstrValid), 32'd0);
        chk("f_a50", 32'(bus.oMemAddr), 32'd50);
        cycle(0, 0, 0, 1, 16'h0050);
        chk("f_pc", 32'(bus.oPC), 32'd50);
        chk("f_i", 32'(bus.oInstr), 32'h0050);

        // Timeout into halt, only reset recovers.
        cycle(0, 0, 0, 0, 16'h0);
        for (int i = 0; i < TIMEOUT - 1; i++)
            cycle(0, 0, 0, 0, 16'h0);
        chk("t_e0", 32'(bus.oError), 32'd0);
        cycle(0, 0, 0, 0, 16'h0);
        chk("t_e1", 32'(bus.oError), 32'd1);
        chk("t_req", 32'(bus.oMemReq), 32'd0);
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 10'd7, 1, 16'h0);
        chk("h_e", 32'(bus.oError), 32'd1);
        chk("h_v", 32'(bus.oInstrValid), 32'd0);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int ack_pct;
            ack_pct = ((i / 250) % 4 == 3) ? 15 : 70;
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 30,
                      $urandom_range(99) < 15,
                      10'($urandom),
                      $urandom_range(99) < ack_pct,
                      16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
